// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage: op encodings and the
// result-queue entry that travels to writeback.
package mem_access_stage_pkg;

  localparam int DATA_W = 16;
  localparam int RD_W   = 3;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              reg_we;
  } result_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of the execute-side handshake, data-memory bus and writeback handshake
// seen by the MEM stage. The stage itself uses the slave view.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              ex_valid;
  logic              ex_ready;
  logic [1:0]        ex_op;
  logic [DATA_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_alu_result;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_reg_we;

  logic [DATA_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_read_data;

  logic              wb_valid;
  logic              wb_ready;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_reg_we;
  logic              err_oob;

  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_store_data, ex_alu_result, ex_rd, ex_reg_we,
    input  mem_read_data, wb_ready,
    output ex_ready, mem_read_addr, mem_write_addr, mem_write_data, mem_we,
    output wb_valid, wb_rd, wb_data, wb_reg_we, err_oob
  );

  modport master (
    output ex_valid, ex_op, ex_addr, ex_store_data, ex_alu_result, ex_rd, ex_reg_we,
    output mem_read_data, wb_ready,
    input  ex_ready, mem_read_addr, mem_write_addr, mem_write_data, mem_we,
    input  wb_valid, wb_rd, wb_data, wb_reg_we, err_oob
  );

endinterface

// File: rtl/mem_access_stage_result_queue.sv
// In-order result FIFO with two push ports (push0 is the older entry) and one
// pop port; head is presented combinationally.
module mem_access_stage_result_queue #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push0,
  input  logic [ENTRY_W-1:0]           push0_entry,
  input  logic                         push1,
  input  logic [ENTRY_W-1:0]           push1_entry,
  input  logic                         pop,
  output logic [ENTRY_W-1:0]           head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   head_reg, tail_reg, tail_plus1;
  logic [CNT_W-1:0]   count_reg;
  logic [1:0]         n_push;
  logic               do_pop;
  logic [ENTRY_W-1:0] first_entry;
  logic [DEPTH-1:0]   wr_first, wr_second;
  logic [ENTRY_W-1:0] slot_q [DEPTH];

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p, input int n);
    return PTR_W'((int'(p) + n) % DEPTH);
  endfunction

  // A lone push1 lands at the tail just like a lone push0.
  assign n_push      = {1'b0, push0} + {1'b0, push1};
  assign first_entry = push0 ? push0_entry : push1_entry;
  assign tail_plus1  = bump(tail_reg, 1);
  assign do_pop      = pop && (count_reg != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [ENTRY_W-1:0] slot_reg;

      assign wr_first[gi]  = (n_push != 2'd0) && (tail_reg == PTR_W'(gi));
      assign wr_second[gi] = (n_push == 2'd2) && (tail_plus1 == PTR_W'(gi));
      assign slot_q[gi]    = slot_reg;

      always_ff @(posedge clk) begin
        if (wr_first[gi]) begin
          slot_reg <= first_entry;
        end else if (wr_second[gi]) begin
          slot_reg <= push1_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      tail_reg  <= bump(tail_reg, int'(n_push));
      head_reg  <= bump(head_reg, int'(do_pop));
      count_reg <= count_reg + CNT_W'(n_push) - CNT_W'(do_pop);
    end
  end

  assign head_entry = slot_q[head_reg];
  assign count      = count_reg;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores to a 1-cycle data memory and retires ALU and
// load results in program order through a credit-limited result queue.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  op_e               op;
  logic              ready, acc, is_load, is_store, oob;
  logic              load_fire, store_fire, alu_fire, pop;
  logic [CNT_W-1:0]  q_count;

  logic              load_pending_reg;
  logic [RD_W-1:0]   load_rd_reg;
  logic              load_we_reg;
  logic              load_oob_reg;
  logic              err_oob_reg;
  logic [DATA_W-1:0] read_addr_reg, write_addr_reg, write_data_reg;
  logic [DATA_W-1:0] read_addr_next, write_addr_next, write_data_next;

  result_t           load_entry, alu_entry, head_entry, hold_reg, wb_entry;

  always_comb begin
    op       = op_e'(bus.ex_op);
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    oob      = |bus.ex_addr[DATA_W-1:ADDR_BITS];
    // Credit covers the load still in flight, so the queue can never overflow.
    ready    = (int'(q_count) + int'(load_pending_reg)) < DEPTH;
    acc      = bus.ex_valid && ready && !reset;
  end

  assign load_fire  = acc && is_load;
  assign store_fire = acc && is_store && !oob;
  assign alu_fire   = acc && !is_load && !is_store;

  assign read_addr_next  = load_fire  ? bus.ex_addr       : read_addr_reg;
  assign write_addr_next = store_fire ? bus.ex_addr       : write_addr_reg;
  assign write_data_next = store_fire ? bus.ex_store_data : write_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_pending_reg <= 1'b0;
      load_rd_reg      <= '0;
      load_we_reg      <= 1'b0;
      load_oob_reg     <= 1'b0;
      err_oob_reg      <= 1'b0;
      read_addr_reg    <= '0;
      write_addr_reg   <= '0;
      write_data_reg   <= '0;
      hold_reg         <= '0;
    end else begin
      load_pending_reg <= load_fire;
      if (load_fire) begin
        load_rd_reg  <= bus.ex_rd;
        load_we_reg  <= bus.ex_reg_we;
        load_oob_reg <= oob;
      end
      err_oob_reg    <= acc && (is_load || is_store) && oob;
      read_addr_reg  <= read_addr_next;
      write_addr_reg <= write_addr_next;
      write_data_reg <= write_data_next;
      if (pop) begin
        hold_reg <= head_entry;
      end
    end
  end

  always_comb begin
    load_entry.rd     = load_rd_reg;
    load_entry.data   = load_oob_reg ? '0 : bus.mem_read_data;
    load_entry.reg_we = load_we_reg;
    alu_entry.rd      = bus.ex_rd;
    alu_entry.data    = bus.ex_alu_result;
    alu_entry.reg_we  = bus.ex_reg_we;
  end

  // The completing load is older than any op accepted this cycle, so it takes push0.
  mem_access_stage_result_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W ($bits(result_t))
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push0       (load_pending_reg),
    .push0_entry (load_entry),
    .push1       (alu_fire),
    .push1_entry (alu_entry),
    .pop         (pop),
    .head_entry  (head_entry),
    .count       (q_count)
  );

  assign pop      = bus.wb_valid && bus.wb_ready;
  assign wb_entry = (q_count != '0) ? head_entry : hold_reg;

  assign bus.ex_ready       = ready;
  assign bus.mem_read_addr  = read_addr_next;
  assign bus.mem_write_addr = write_addr_next;
  assign bus.mem_write_data = write_data_next;
  assign bus.mem_we         = store_fire;
  assign bus.wb_valid       = (q_count != '0);
  assign bus.wb_rd          = wb_entry.rd;
  assign bus.wb_data        = wb_entry.data;
  assign bus.wb_reg_we      = wb_entry.reg_we;
  assign bus.err_oob        = err_oob_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver predicts each result in
// program order from a word-array memory model; a monitor pops and compares.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_access_stage_if bus();

  mem_access_stage #(.ADDR_BITS(4), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] tmem [16];
  logic [15:0] model_mem [16];
  result_t     exp_q [$];
  bit          err_at [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  bit          rand_ready = 0;
  bit          ready_ctl = 1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) tmem[bus.mem_write_addr[3:0]] <= bus.mem_write_data;
    bus.mem_read_data <= tmem[bus.mem_read_addr[3:0]];
  end

  initial begin
    bus.wb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.wb_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_ctl;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    result_t e;
    if (mon_en && !reset) begin
      check("err_oob", {31'b0, bus.err_oob}, {31'b0, err_at.exists(cyc)});
      if (bus.wb_valid && bus.wb_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h with nothing expected", bus.wb_rd, bus.wb_data);
        end else begin
          e = exp_q.pop_front();
          $display("wb pop: rd=%0d data=%h we=%0d (exp rd=%0d data=%h we=%0d)",
                   bus.wb_rd, bus.wb_data, bus.wb_reg_we, e.rd, e.data, e.reg_we);
          check("wb_rd", {29'b0, bus.wb_rd}, {29'b0, e.rd});
          check("wb_data", {16'b0, bus.wb_data}, {16'b0, e.data});
          check("wb_reg_we", {31'b0, bus.wb_reg_we}, {31'b0, e.reg_we});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] sd,
                       input logic [15:0] alu, input logic [2:0] rd, input logic we);
    bit      done = 0;
    int      waits = 0;
    bit      oob;
    result_t e;
    bus.ex_valid = 1'b1;
    bus.ex_op = op;
    bus.ex_addr = addr;
    bus.ex_store_data = sd;
    bus.ex_alu_result = alu;
    bus.ex_rd = rd;
    bus.ex_reg_we = we;
    oob = (addr[15:4] != 12'h0);
    while (!done) begin
      @(negedge clk);
      if (bus.ex_ready) begin
        done = 1;
        $display("issue: op=%0d addr=%h sd=%h alu=%h rd=%0d we=%0d", op, addr, sd, alu, rd, we);
        if (op == 2'b01) begin
          e.rd = rd;
          e.data = oob ? 16'h0 : model_mem[addr[3:0]];
          e.reg_we = we;
          exp_q.push_back(e);
          if (oob) err_at[cyc + 1] = 1;
          check("mem_read_addr", {16'b0, bus.mem_read_addr}, {16'b0, addr});
          check("mem_we_load", {31'b0, bus.mem_we}, 32'd0);
        end else if (op == 2'b10) begin
          if (oob) err_at[cyc + 1] = 1;
          else model_mem[addr[3:0]] = sd;
          check("mem_we_store", {31'b0, bus.mem_we}, {31'b0, !oob});
          if (!oob) begin
            check("mem_write_addr", {16'b0, bus.mem_write_addr}, {16'b0, addr});
            check("mem_write_data", {16'b0, bus.mem_write_data}, {16'b0, sd});
          end
        end else begin
          e.rd = rd;
          e.data = alu;
          e.reg_we = we;
          exp_q.push_back(e);
          check("mem_we_alu", {31'b0, bus.mem_we}, 32'd0);
        end
      end else if (++waits > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: ex_ready stayed 0 for %0d cycles, required 1", waits);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.ex_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    bus.ex_valid = 0;
    bus.ex_op = 0;
    bus.ex_addr = 0;
    bus.ex_store_data = 0;
    bus.ex_alu_result = 0;
    bus.ex_rd = 0;
    bus.ex_reg_we = 0;
    for (int i = 0; i < 16; i++) tmem[i] = 16'($urandom);
    tmem[3] = 16'hBEEF;
    for (int i = 0; i < 16; i++) model_mem[i] = tmem[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check("rst_wb_rd", {29'b0, bus.wb_rd}, 32'd0);
    check("rst_wb_data", {16'b0, bus.wb_data}, 32'd0);
    check("rst_wb_reg_we", {31'b0, bus.wb_reg_we}, 32'd0);
    check("rst_err_oob", {31'b0, bus.err_oob}, 32'd0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_mem_read_addr", {16'b0, bus.mem_read_addr}, 32'd0);
    check("rst_mem_write_addr", {16'b0, bus.mem_write_addr}, 32'd0);
    check("rst_mem_write_data", {16'b0, bus.mem_write_data}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1;

    // Load latency 2, passthrough latency 1.
    issue(2'b01, 16'd3, 16'h0, 16'h0, 3'd5, 1'b1);
    @(negedge clk);
    check("load_lat_t1", {31'b0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    check("load_lat_t2", {31'b0, bus.wb_valid}, 32'd1);
    drain();
    issue(2'b00, 16'h0, 16'h0, 16'h0055, 3'd1, 1'b1);
    @(negedge clk);
    check("alu_lat_t1", {31'b0, bus.wb_valid}, 32'd1);
    drain();

    // Store then immediate load of the same word.
    issue(2'b10, 16'd7, 16'h1234, 16'h0, 3'd0, 1'b0);
    issue(2'b01, 16'd7, 16'h0, 16'h0, 3'd2, 1'b1);
    drain();

    // Credit exhaustion under backpressure, then in-order release.
    ready_ctl = 0;
    @(posedge clk);
    #3;
    issue(2'b01, 16'd2, 16'h0, 16'h0, 3'd3, 1'b1);
    issue(2'b00, 16'h0, 16'h0, 16'h00AA, 3'd4, 1'b1);
    bus.ex_valid = 1'b1;
    bus.ex_op = 2'b00;
    bus.ex_alu_result = 16'h0777;
    bus.ex_rd = 3'd6;
    repeat (3) begin
      @(negedge clk);
      check("ex_ready_full", {31'b0, bus.ex_ready}, 32'd0);
    end
    ready_ctl = 1;
    issue(2'b00, 16'h0, 16'h0, 16'h0777, 3'd6, 1'b0);
    drain();

    // Dual push with writeback flowing; reserved op behaves as passthrough.
    issue(2'b01, 16'd2, 16'h0, 16'h0, 3'd1, 1'b1);
    issue(2'b11, 16'h0, 16'h0, 16'h0BCD, 3'd2, 1'b1);
    drain();

    // Out-of-range store is dropped; out-of-range load returns 0.
    issue(2'b10, 16'h0013, 16'hDEAD, 16'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    issue(2'b01, 16'd3, 16'h0, 16'h0, 3'd4, 1'b1);
    issue(2'b01, 16'h0100, 16'h0, 16'h0, 3'd7, 1'b1);
    drain();

    // Reset while a load is in flight and the queue fills.
    ready_ctl = 0;
    @(posedge clk);
    #3;
    issue(2'b00, 16'h0, 16'h0, 16'h1111, 3'd1, 1'b1);
    issue(2'b01, 16'd5, 16'h0, 16'h0, 3'd2, 1'b1);
    mon_en = 0;
    reset = 1'b1;
    #1;
    check("async_clear_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ready_ctl = 1;
    mon_en = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
      check("post_rst_ex_ready", {31'b0, bus.ex_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random writeback backpressure.
    rand_ready = 1;
    for (int n = 0; n < 250; n++) begin
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        a = 16'($urandom);
        if (a[15:4] == 12'h0) a[15:4] = 12'h1;
      end
      issue(2'($urandom_range(0, 3)), a, 16'($urandom), 16'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 0;
    ready_ctl = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage of the 6-stage 16-bit RISC core.
- Sits between the execute stage and the data-memory controller, and feeds the writeback stage.
- Issues loads and stores to the 1-cycle-latency memory controller and retires results in program order.
- Buffers results in a small in-order queue so writeback backpressure never loses registered load data.

Parameters:
- DATA_W, 16, data/address width.
- ADDR_BITS, 4, physical memory index bits; the memory holds 2^ADDR_BITS words.
- RD_W, 3, destination register index width.
- DEPTH, 2, result-queue entries; this is also the credit limit.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents an op.
- ex_ready  out  1  stage accepts the op this cycle.
- ex_op  in  2  00=ALU passthrough, 01=load, 10=store, 11=reserved (treated as 00).
- ex_addr  in  DATA_W  effective address.
- ex_store_data  in  DATA_W  store data.
- ex_alu_result  in  DATA_W  result for passthrough ops.
- ex_rd  in  RD_W  destination register.
- ex_reg_we  in  1  op writes the register file.
- mem_read_addr  out  DATA_W  memory read address.
- mem_write_addr  out  DATA_W  memory write address.
- mem_write_data  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_read_data  in  DATA_W  registered read data; valid one cycle after the address is presented.
- wb_valid  out  1  result available to writeback.
- wb_ready  in  1  writeback consumes the result.
- wb_rd  out  RD_W  destination register.
- wb_data  out  DATA_W  result data.
- wb_reg_we  out  1  register write enable for the result.
- err_oob  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Accept: acc = ex_valid && ex_ready.
- Credit rule: ex_ready = (q_count + load_pending) < DEPTH. ex_ready is combinational from registered state only and never depends on ex_valid.
- Load, accepted in cycle t:
  - mem_read_addr = ex_addr combinationally in cycle t.
  - load_pending is set at edge t, with rd and reg_we captured.
  - In cycle t+1, mem_read_data is pushed into the queue at edge t+1.
- Store, accepted:
  - mem_we=1, mem_write_addr=ex_addr, mem_write_data=ex_store_data, all combinationally in the same cycle.
  - No queue entry is created.
- Passthrough, accepted: {ex_rd, ex_alu_result, ex_reg_we} is pushed at the same edge.
- Idle outputs: mem_we=0 whenever there is no accepted store. mem_read_addr holds its last load address; the value is don't-care but must be stable.
- Out of range: ex_addr[DATA_W-1:ADDR_BITS] != 0 on a load or store.
  - err_oob pulses high for the cycle after acceptance.
  - A store is suppressed (mem_we=0).
  - A load completes normally in order but returns data 0.
- Ordering: in one cycle, a load completion and a newly accepted passthrough may both push. The load entry is older and is enqueued first; the queue supports 2 pushes per cycle.
- Queue:
  - In-order FIFO of DEPTH entries.
  - wb_* driven from the head entry; wb_valid = q_count != 0.
  - Pop when wb_valid && wb_ready.
  - Push and pop in the same cycle is allowed, including when full. The credit rule guarantees no overflow.
  - Queue empty means wb_valid=0 and wb_data holds its last value.
- Latency with wb_ready=1:
  - Passthrough: 1 cycle from acceptance to wb_valid.
  - Load: 2 cycles from acceptance to wb_valid.
- Reset (asynchronous, any time):
  - Queue, q_count and load_pending are cleared; any in-flight load is discarded.
  - wb_valid=0, wb_rd=0, wb_data=0, wb_reg_we=0, err_oob=0, mem_we=0, mem_read_addr=0, mem_write_addr=0, mem_write_data=0.
- Back-to-back: store to A at t, then load from A at t+1 must return the stored value. The memory write occurs at edge t and the read at edge t+1, so no forwarding logic is required.

Decomposition:
- Shared package holds:
  - op encodings OP_ALU, OP_LOAD, OP_STORE.
  - DATA_W and RD_W constants.
  - the result-entry struct {rd, data, reg_we}.
- One sub-module, result_queue: parameterised in-order FIFO with a dual-push port and a single pop port, plus a count output.

Test Plan:
- Memory preloaded with word 3=16'hBEEF; load addr 3, rd=5, wb_ready=1 → wb_valid two cycles after acceptance, wb_rd=5, wb_data=16'hBEEF.
- Store 16'h1234 to addr 7 at t, load addr 7 at t+1 → mem_we=1 only in cycle t; the load returns 16'h1234.
- wb_ready=0; issue load, passthrough (result 16'h00AA), then a third op → ex_ready drops after 2 credits. Raise wb_ready → results pop in order, load data first, then 16'h00AA.
- Load addr 2 at t, passthrough at t+1 → dual push in one cycle; wb order is load then passthrough.
- Store to addr 16'h0013 → mem_we stays 0, err_oob pulses for 1 cycle, memory unchanged. Load addr 16'h0100 → err_oob pulses and wb_data=0.
- Assert reset while a load is pending and the queue is full → wb_valid=0 and ex_ready=1 the cycle after release; no stale result ever appears.
